// File: rtl/perm_arb.sv
// perm_arb: arbitrates 8-beat blocks from two requesters into one permutation engine and routes results back by tag.
module perm_arb #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         r0_pushin,
  input  logic [2:0]   r0_dix,
  input  logic [199:0] r0_din,
  input  logic         r1_pushin,
  input  logic [2:0]   r1_dix,
  input  logic [199:0] r1_din,
  output logic         r0_stall,
  output logic         r1_stall,
  output logic         p_pushin,
  output logic [2:0]   p_dix,
  output logic [199:0] p_din,
  input  logic         p_pushout,
  input  logic [2:0]   p_doutix,
  input  logic [199:0] p_dout,
  output logic         r0_pushout,
  output logic         r1_pushout,
  output logic [2:0]   r0_doutix,
  output logic [2:0]   r1_doutix,
  output logic [199:0] r0_dout,
  output logic [199:0] r1_dout,
  output logic         err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_state;
  logic [2:0] r_cnt, w_cnt, w_dix;
  logic r_gnt, w_gnt, r_rr, w_rr;
  logic [DEPTH-1:0] r_tag;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_full, w_empty, w_c0, w_c1, w_acc0, w_acc1, w_acc;
  logic w_push, w_fwd, w_sel, w_bad, w_hit, w_head, w_pop;
  assign w_full = r_count == (AW+1)'(DEPTH);
  assign w_empty = r_count == '0;
  assign w_c0 = r0_pushin && r0_dix == 3'd0;
  assign w_c1 = r1_pushin && r1_dix == 3'd0;
  // a block start is held off when every tag slot is taken; otherwise only the lock or a lost tie stalls
  assign r0_stall = reset || (r0_pushin && ((w_c0 && w_full) || (r_state == IDLE ? w_c0 && w_c1 && r_rr : r_gnt)));
  assign r1_stall = reset || (r1_pushin && ((w_c1 && w_full) || (r_state == IDLE ? w_c0 && w_c1 && !r_rr : !r_gnt)));
  assign w_acc0 = r0_pushin && !r0_stall;
  assign w_acc1 = r1_pushin && !r1_stall;
  assign w_acc = r_gnt ? w_acc1 : w_acc0;
  assign w_dix = r_gnt ? r1_dix : r0_dix;
  assign w_hit = p_pushout && !w_empty;
  assign w_head = r_tag[r_rp];
  assign w_pop = w_hit && p_doutix == 3'd7;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_gnt = r_gnt;
    w_rr = r_rr;
    w_push = 1'b0;
    w_fwd = 1'b0;
    w_sel = r_gnt;
    w_bad = 1'b0;
    if (r_state == IDLE) begin
      w_push = (w_acc0 && w_c0) || (w_acc1 && w_c1);
      w_sel = !(w_acc0 && w_c0);
      w_bad = (w_acc0 && !w_c0) || (w_acc1 && !w_c1);
      w_fwd = w_push;
      if (w_push) begin
        w_state = BURST;
        w_cnt = 3'd1;
        w_gnt = w_sel;
        w_rr = !w_sel;
      end
    end else if (w_acc) begin
      w_fwd = w_dix == r_cnt;
      w_bad = !w_fwd;
      if (w_fwd) begin
        w_cnt = r_cnt + 3'd1;
        w_state = r_cnt == 3'd7 ? IDLE : BURST;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_gnt <= 1'b0;
      r_rr <= 1'b0;
      r_tag <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      err <= 1'b0;
      p_pushin <= 1'b0;
      p_dix <= '0;
      p_din <= '0;
      r0_pushout <= 1'b0;
      r1_pushout <= 1'b0;
      r0_doutix <= '0;
      r1_doutix <= '0;
      r0_dout <= '0;
      r1_dout <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_gnt <= w_gnt;
      r_rr <= w_rr;
      if (w_push) begin
        r_tag[r_wp] <= w_sel;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      err <= err || w_bad || (p_pushout && w_empty);
      p_pushin <= w_fwd;
      if (w_fwd) begin
        p_dix <= w_sel ? r1_dix : r0_dix;
        p_din <= w_sel ? r1_din : r0_din;
      end
      r0_pushout <= w_hit && !w_head;
      r1_pushout <= w_hit && w_head;
      if (w_hit && !w_head) begin
        r0_doutix <= p_doutix;
        r0_dout <= p_dout;
      end
      if (w_hit && w_head) begin
        r1_doutix <= p_doutix;
        r1_dout <= p_dout;
      end
    end
  end
endmodule

// File: tb/tb_perm_arb.sv
// tb_perm_arb: randomized and directed bench for perm_arb against a queue-based behavioural model.
module tb_perm_arb;
  localparam int DEPTH = 4;
  typedef struct {logic [2:0] dix; logic [199:0] din; int gap;} beat_t;
  typedef struct {logic [2:0] ix; logic [199:0] d;} res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pin [2] = '{1'b0, 1'b0};
  logic [2:0] pdix [2] = '{3'd0, 3'd0};
  logic [199:0] pdin [2] = '{200'd0, 200'd0};
  logic r0_stall, r1_stall, p_pushin, r0_pushout, r1_pushout, err;
  logic [2:0] p_dix, r0_doutix, r1_doutix;
  logic [199:0] p_din, r0_dout, r1_dout;
  logic p_pushout = 1'b0;
  logic [2:0] p_doutix = '0;
  logic [199:0] p_dout = '0;
  int nchk = 0, nerr = 0, gcnt [2] = '{0, 0};
  bit started = 0, hold = 0, stray = 0;
  beat_t rq [2][$];
  res_t pq [$];
  logic [199:0] col [$];
  bit m_busy = 0, m_own = 0, m_rr = 0, m_err = 0, tagq [$];
  int m_exp = 0;
  bit e_pp = 0, e_rp [2] = '{0, 0};
  logic [2:0] e_pdix = '0, e_rdix [2] = '{3'd0, 3'd0};
  logic [199:0] e_pdin = '0, e_rdout [2] = '{200'd0, 200'd0};
  bit acc [2], b, t;
  always #5 clk = ~clk;
  perm_arb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .r0_pushin(pin[0]), .r0_dix(pdix[0]), .r0_din(pdin[0]),
    .r1_pushin(pin[1]), .r1_dix(pdix[1]), .r1_din(pdin[1]),
    .r0_stall(r0_stall), .r1_stall(r1_stall),
    .p_pushin(p_pushin), .p_dix(p_dix), .p_din(p_din),
    .p_pushout(p_pushout), .p_doutix(p_doutix), .p_dout(p_dout),
    .r0_pushout(r0_pushout), .r1_pushout(r1_pushout),
    .r0_doutix(r0_doutix), .r1_doutix(r1_doutix),
    .r0_dout(r0_dout), .r1_dout(r1_dout), .err(err)
  );
  function automatic logic [199:0] rnd200();
    logic [223:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return v[199:0];
  endfunction
  function automatic bit exp_stall(int n);
    int o = 1 - n;
    if (reset) return 1;
    if (!pin[n]) return 0;
    if (pdix[n] == 3'd0 && tagq.size() == DEPTH) return 1;
    if (!m_busy) return pdix[n] == 3'd0 && pin[o] && pdix[o] == 3'd0 && int'(m_rr) != n;
    return int'(m_own) != n;
  endfunction
  task automatic chk(string nm, logic [199:0] a, logic [199:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic tmo(string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask
  task automatic sync();
    @(posedge clk);
    #2;
  endtask
  task automatic add_block(int n, int maxgap, bit bad);
    int k = $urandom_range(1, 7);
    int d;
    for (int i = 0; i < 8; i++) begin
      if (bad && i == k) begin
        do d = $urandom_range(1, 7); while (d == k);
        rq[n].push_back('{dix: 3'(d), din: rnd200(), gap: 0});
      end
      rq[n].push_back('{dix: 3'(i), din: rnd200(), gap: $urandom_range(0, maxgap)});
    end
  endtask
  task automatic reset_on();
    sync();
    reset = 1'b1;
    rq[0].delete();
    rq[1].delete();
    hold = 0;
    pq.delete();
    col.delete();
  endtask
  task automatic reset_off();
    @(posedge clk);
    #2;
    reset = 1'b0;
    pq.delete();
    col.delete();
  endtask
  task automatic wait_idle(int max);
    int c = 0;
    while (!(rq[0].size() == 0 && rq[1].size() == 0 && !pin[0] && !pin[1] && pq.size() == 0 &&
             col.size() == 0 && tagq.size() == 0 && !m_busy && !p_pushout) && c < max) begin
      @(posedge clk);
      c++;
    end
    if (c >= max) tmo("wait_idle");
    repeat (3) @(posedge clk);
  endtask
  always @(posedge clk) begin
    started = 1;
    for (int n = 0; n < 2; n++) acc[n] = pin[n] && !exp_stall(n);
    if (reset) begin
      m_busy = 0; m_own = 0; m_rr = 0; m_err = 0; m_exp = 0;
      tagq.delete();
      e_pp = 0; e_pdix = '0; e_pdin = '0;
      for (int n = 0; n < 2; n++) begin
        e_rp[n] = 0; e_rdix[n] = '0; e_rdout[n] = '0;
      end
    end else begin
      e_rp[0] = 0;
      e_rp[1] = 0;
      if (p_pushout) begin
        if (tagq.size() == 0) m_err = 1;
        else begin
          t = tagq[0];
          e_rp[t] = 1;
          e_rdix[t] = p_doutix;
          e_rdout[t] = p_dout;
          if (p_doutix == 3'd7) void'(tagq.pop_front());
        end
      end
      e_pp = 0;
      b = m_busy;
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) begin
          if (!b) begin
            if (pdix[n] == 3'd0) begin
              m_busy = 1; m_own = n[0]; m_exp = 1; m_rr = (n == 0);
              tagq.push_back(n[0]);
              e_pp = 1; e_pdix = 3'd0; e_pdin = pdin[n];
            end else m_err = 1;
          end else if (int'(pdix[n]) == m_exp) begin
            e_pp = 1; e_pdix = pdix[n]; e_pdin = pdin[n];
            m_exp++;
            if (pdix[n] == 3'd7) m_busy = 0;
          end else m_err = 1;
        end
      end
    end
    #1;
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        pin[n] = 1'b0;
        gcnt[n] = 0;
      end else begin
        if (acc[n]) pin[n] = 1'b0;
        if (!pin[n] && rq[n].size() > 0) begin
          if (gcnt[n] < rq[n][0].gap) gcnt[n]++;
          else begin
            pin[n] = 1'b1; pdix[n] = rq[n][0].dix; pdin[n] = rq[n][0].din;
            void'(rq[n].pop_front());
            gcnt[n] = 0;
          end
        end
      end
    end
    p_pushout = 1'b0;
    if (stray) begin
      p_pushout = 1'b1; p_doutix = 3'd7; p_dout = rnd200();
      stray = 0;
    end else if (!hold && !reset && pq.size() > 0 && $urandom_range(0, 3) != 0) begin
      p_pushout = 1'b1; p_doutix = pq[0].ix; p_dout = pq[0].d;
      void'(pq.pop_front());
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("r0_stall", r0_stall, exp_stall(0));
      chk("r1_stall", r1_stall, exp_stall(1));
      chk("p_pushin", p_pushin, e_pp);
      if (e_pp) begin
        chk("p_dix", p_dix, e_pdix);
        chk("p_din", p_din, e_pdin);
      end
      chk("r0_pushout", r0_pushout, e_rp[0]);
      chk("r1_pushout", r1_pushout, e_rp[1]);
      chk("r0_doutix", r0_doutix, e_rdix[0]);
      chk("r1_doutix", r1_doutix, e_rdix[1]);
      chk("r0_dout", r0_dout, e_rdout[0]);
      chk("r1_dout", r1_dout, e_rdout[1]);
      chk("err", err, m_err);
      if (p_pushin === 1'b1) begin
        col.push_back(p_din);
        if (col.size() == 8) begin
          for (int i = 0; i < 8; i++) pq.push_back('{ix: 3'(i), d: ~col[i]});
          col.delete();
        end
      end
    end
  end
  initial begin
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r0_stall", r0_stall, 1);
    chk("rst_p_pushin", p_pushin, 0);
    chk("rst_err", err, 0);
    chk("rst_r1_dout", r1_dout, 0);
    reset_off();
    stray = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("stray_err", err, 1);
    reset_on();
    reset_off();
    add_block(0, 3, 0);
    wait_idle(500);
    reset_on();
    reset_off();
    add_block(0, 0, 0);
    add_block(1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("tie1_r0_stall", r0_stall, 0);
    chk("tie1_r1_stall", r1_stall, 1);
    wait_idle(500);
    sync();
    add_block(0, 0, 0);
    add_block(1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("tie2_r0_stall", r0_stall, 0);
    chk("tie2_r1_stall", r1_stall, 1);
    wait_idle(500);
    reset_on();
    reset_off();
    hold = 1;
    for (int k = 0; k < 5; k++) add_block(1, 0, 0);
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      if (pin[1] && pdix[1] == 3'd0 && tagq.size() == DEPTH) break;
    end
    if (c == 400) tmo("full_wait");
    chk("full_r1_stall", r1_stall, 1);
    hold = 0;
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      if (p_pushout && p_doutix == 3'd7) break;
    end
    if (c == 400) tmo("pop_wait");
    chk("pop_r1_stall_before", r1_stall, 1);
    @(negedge clk);
    chk("pop_r1_stall_after", r1_stall, 0);
    wait_idle(1000);
    reset_on();
    reset_off();
    foreach (rq[0][i]) rq[0][i].gap = 0;
    rq[0].push_back('{dix: 3'd0, din: rnd200(), gap: 0});
    rq[0].push_back('{dix: 3'd1, din: rnd200(), gap: 1});
    rq[0].push_back('{dix: 3'd3, din: rnd200(), gap: 0});
    for (int k = 2; k < 8; k++) rq[0].push_back('{dix: 3'(k), din: rnd200(), gap: $urandom_range(0, 2)});
    wait_idle(500);
    chk("bad_err_sticky", err, 1);
    reset_on();
    reset_off();
    add_block(1, 1, 0);
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_busy && m_own && m_exp == 5) break;
    end
    if (c == 200) tmo("mid_wait");
    reset_on();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_p_pushin", p_pushin, 0);
    chk("mid_p_dix", p_dix, 0);
    chk("mid_r1_pushout", r1_pushout, 0);
    chk("mid_r1_doutix", r1_doutix, 0);
    chk("mid_r0_dout", r0_dout, 0);
    chk("mid_err", err, 0);
    chk("mid_r1_stall", r1_stall, 1);
    reset_off();
    add_block(0, 2, 0);
    wait_idle(500);
    chk("post_rst_err", err, 0);
    sync();
    add_block(0, 1, 0);
    add_block(1, 1, 0);
    add_block(0, 1, 0);
    wait_idle(1000);
    for (int r = 0; r < 12; r++) begin
      sync();
      for (int n = 0; n < 2; n++) begin
        int nb = $urandom_range(0, 3);
        for (int k = 0; k < nb; k++) add_block(n, 2, $urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        hold = 1;
        repeat ($urandom_range(5, 40)) @(posedge clk);
        #2;
        hold = 0;
      end
      wait_idle(3000);
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/perm_arb.md
PERM_ARB -- requirements
Module: perm_arb

Interface
REQ-001 Parameter DEPTH, default 4, max permutation blocks outstanding in perm; power of 2, >=2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 r0_pushin, r1_pushin  input  1 each  requester beat valid.
REQ-005 r0_dix, r1_dix  input  3 each  requester beat index (200-bit slice of 1600-bit state).
REQ-006 r0_din, r1_din  input  200 each  requester beat data.
REQ-007 r0_stall, r1_stall  output  1 each  beat not accepted this cycle; requester holds pushin/dix/din.
REQ-008 p_pushin, p_dix[2:0], p_din[199:0]  output  beat to perm engine.
REQ-009 p_pushout, p_doutix[2:0], p_dout[199:0]  input  result beat from perm engine; no backpressure.
REQ-010 r0_pushout, r1_pushout (1), r0_doutix, r1_doutix (3), r0_dout, r1_dout (200)  output  routed results.
REQ-011 err  output  1  sticky protocol-error flag.

Function
REQ-012 Block = 8 beats, dix 0..7 in order; idle gaps between beats of a block allowed.
REQ-013 Beat on requester N accepted on a rising edge where rN_pushin=1 and rN_stall=0.
REQ-014 States: IDLE (no block in progress), BURST (grant locked to one requester, 3-bit expected-dix counter).
REQ-015 IDLE: candidates = requesters with pushin=1 and dix=0; none -> stay IDLE.
REQ-016 IDLE, one candidate: grant it; both: grant rr pointer (reset 0); pointer flips to other requester after each grant.
REQ-017 Grant and acceptance of dix=0 occur in same cycle; counter -> 1; state -> BURST.
REQ-018 BURST: only granted requester may have beats accepted; other requester's stall=1 whenever its pushin=1.
REQ-019 BURST: accepted beat with dix==counter forwarded, counter increments; dix==7 accepted -> IDLE.
REQ-020 BURST: granted beat with dix!=counter accepted (stall=0) but dropped, err set, counter unchanged.
REQ-021 IDLE: beat with dix!=0 accepted and dropped, err set.
REQ-022 rN_stall=1 for dix=0 beats when tag FIFO count==DEPTH (count before same-cycle pop; no bypass).
REQ-023 rN_stall combinational from rN_pushin, rN_dix, state, grant, rr pointer, FIFO count; 0 when rN_pushin=0.
REQ-024 Forwarded beat appears on p_pushin/p_dix/p_din exactly 1 cycle after acceptance; p_pushin=0 otherwise.
REQ-025 Tag FIFO (DEPTH entries, 1-bit requester id): push on acceptance of dix=0; pop on p_pushout=1 with p_doutix=7.
REQ-026 Same-cycle push and pop: both performed, count unchanged.
REQ-027 p_pushout beat routed to requester at FIFO head; rN_pushout/doutix/dout registered, 1-cycle latency.
REQ-028 Non-selected requester outputs: pushout=0, doutix/dout hold last values.
REQ-029 p_pushout=1 with FIFO empty: beat dropped, err set.
REQ-030 All outputs driven from flops or state-only logic except rN_stall; no X on any output after reset.

Reset
REQ-031 reset=1: state IDLE, counter 0, rr pointer 0, FIFO empty, err 0.
REQ-032 reset=1: p_pushin, r0/r1_pushout 0; p_dix, p_din, doutix, dout all 0; rN_stall=1 while reset=1.
REQ-033 Reset mid-burst or with blocks outstanding discards all state; first cycle after release behaves as IDLE.

Verification
REQ-034 r0 pushes dix 0..7 with random gaps -> p_pushin beats dix 0..7 same data, 1 cycle later; perm model results -> r0_pushout x8, r1_pushout=0, err=0.
REQ-035 r0, r1 present dix=0 same cycle after reset -> r0 granted, r1_stall=1 until r0 dix=7 accepted; r1 then granted; next tie -> r0.
REQ-036 r1 issues 4 back-to-back blocks, perm model withholds results -> 5th dix=0 stalled; first p_doutix=7 pop -> stall drops next cycle.
REQ-037 r0 sends dix 0,1,3 -> beat 3 dropped, err=1 and sticky; resending dix 2..7 completes block normally.
REQ-038 reset asserted after r1 beat dix=4 -> all outputs reset values; new r0 block after release forwarded correctly, err=0.
REQ-039 Interleaved blocks r0,r1,r0 -> each 8-beat result burst routed to originating requester in issue order.
